trap_ctrl: RTL and testbench

Trap sequencer sitting between the commit stage and the machine-mode CSR file. It detects traps at the commit boundary: enabled pending interrupts, illegal instructions, ecall and mret. It prioritises them, drains the pipeline, issues exactly one trap-update command to the CSR file, and then redirects fetch to the handler or to the return address. This guarantees that CSR trap updates and PC redirection happen atomically, once per trap.

---
 rtl/trap_ctrl_pkg.sv | 31 +++
 rtl/trap_ctrl_int_prio_enc.sv | 30 +++
 rtl/trap_ctrl.sv | 139 +++++++++++++
 tb/tb_trap_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared trap sequencing types and machine-mode cause constants used by
// the trap controller and its interrupt priority encoder.
package trap_ctrl_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_UPDATE   = 2'd2,
      ST_REDIRECT = 2'd3
   } trap_state_t;

   typedef enum logic {
      KIND_ENTER  = 1'b0,
      KIND_RETURN = 1'b1
   } trap_kind_t;

   localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
   localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
   localparam logic [3:0] CAUSE_MEI     = 4'd11;
   localparam logic [3:0] CAUSE_MSI     = 4'd3;
   localparam logic [3:0] CAUSE_MTI     = 4'd7;

   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

   function automatic logic [XLEN-1:0] zext_code(input logic [3:0] code);
      return {{(XLEN-4){1'b0}}, code};
   endfunction

endpackage

// File: rtl/trap_ctrl_int_prio_enc.sv
// Picks the highest-priority machine interrupt from the enabled pending set.
// Only MEI, MSI and MTI are recognised; every other bit is ignored.
module int_prio_enc
   import trap_ctrl_pkg::*;
(
   input  logic [XLEN-1:0] pend,
   output logic            irq_valid,
   output logic [3:0]      irq_code
);

   // Fixed priority: external > software > timer.
   always_comb begin
      irq_valid = 1'b0;
      irq_code  = 4'd0;
      if (pend[int'(CAUSE_MEI)]) begin
         irq_valid = 1'b1;
         irq_code  = CAUSE_MEI;
      end else if (pend[int'(CAUSE_MSI)]) begin
         irq_valid = 1'b1;
         irq_code  = CAUSE_MSI;
      end else if (pend[int'(CAUSE_MTI)]) begin
         irq_valid = 1'b1;
         irq_code  = CAUSE_MTI;
      end else begin
         irq_valid = 1'b0;
         irq_code  = 4'd0;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: detects a trap at commit, drains the pipeline, issues one
// CSR trap command and then redirects fetch, so the CSR update and PC change stay atomic.
module trap_ctrl
   import trap_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic            commit_ecall,
   input  logic            commit_mret,
   input  logic            commit_illegal,
   input  logic [XLEN-1:0] commit_tval,
   input  logic [1:0]      pmode,
   input  logic            mstatus_mie,
   input  logic [XLEN-1:0] mip,
   input  logic [XLEN-1:0] mie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic            pipe_empty,
   input  logic            redirect_ready,
   output logic            commit_stall,
   output logic            flush,
   output logic            csr_cmd_valid,
   output logic            csr_cmd_kind,
   output logic [XLEN-1:0] csr_cmd_cause,
   output logic [XLEN-1:0] csr_cmd_epc,
   output logic [XLEN-1:0] csr_cmd_tval,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   trap_state_t     state_q, state_d;
   trap_kind_t      kind_q, kind_d, ev_kind;
   logic [XLEN-1:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d;
   logic [XLEN-1:0] rdpc_q, rdpc_d, ev_cause, ev_tval, target, base;
   logic            stall_q, stall_d, flush_q, flush_d;
   logic            cmd_valid_q, cmd_valid_d, rdv_q, rdv_d;
   logic            irq_valid, ev_found, accept;
   logic [3:0]      irq_code;

   int_prio_enc u_int_prio_enc (
      .pend      (mip & mie),
      .irq_valid (irq_valid),
      .irq_code  (irq_code)
   );

   // Classify the committing instruction by trap priority.
   always_comb begin
      ev_found = 1'b1;
      ev_kind  = KIND_ENTER;
      ev_cause = {XLEN{1'b0}};
      ev_tval  = {XLEN{1'b0}};
      if (mstatus_mie && irq_valid) begin
         ev_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};
      end else if (commit_illegal || (commit_mret && (pmode != 2'd3))) begin
         ev_cause = zext_code(CAUSE_ILLEGAL);
         ev_tval  = commit_tval;
      end else if (commit_ecall) begin
         ev_cause = zext_code(CAUSE_ECALL_U + {2'b00, pmode});
      end else if (commit_mret) begin
         ev_kind  = KIND_RETURN;
      end else begin
         ev_found = 1'b0;
      end
   end

   // Redirect target; vectoring applies only to interrupts in vectored mode.
   always_comb begin
      base = {mtvec[XLEN-1:2], 2'b00};
      if (kind_q == KIND_RETURN) begin
         target = mepc;
      end else if ((mtvec[1:0] == MTVEC_MODE_VECTORED) && cause_q[XLEN-1]) begin
         target = base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
      end else begin
         target = base;
      end
   end

   // Next state, latched trap fields and registered outputs.
   always_comb begin
      accept  = (state_q == ST_IDLE) && commit_valid && ev_found;
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (accept) state_d = ST_DRAIN; else state_d = ST_IDLE;
         ST_DRAIN:    if (pipe_empty) state_d = ST_UPDATE; else state_d = ST_DRAIN;
         ST_UPDATE:   state_d = ST_REDIRECT;
         ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE; else state_d = ST_REDIRECT;
         default:     state_d = ST_IDLE;
      endcase
      kind_d      = accept ? ev_kind  : kind_q;
      cause_d     = accept ? ev_cause : cause_q;
      epc_d       = accept ? commit_pc : epc_q;
      tval_d      = accept ? ev_tval  : tval_q;
      rdpc_d      = (state_q == ST_UPDATE) ? target : rdpc_q;
      stall_d     = (state_d != ST_IDLE);
      flush_d     = (state_d == ST_DRAIN);
      cmd_valid_d = (state_d == ST_UPDATE);
      rdv_d       = (state_d == ST_REDIRECT);
   end

   // State and output registers; reset discards any partially sequenced trap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         kind_q      <= KIND_ENTER;
         cause_q     <= {XLEN{1'b0}};
         epc_q       <= {XLEN{1'b0}};
         tval_q      <= {XLEN{1'b0}};
         rdpc_q      <= {XLEN{1'b0}};
         stall_q     <= 1'b0;
         flush_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         rdv_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         cause_q     <= cause_d;
         epc_q       <= epc_d;
         tval_q      <= tval_d;
         rdpc_q      <= rdpc_d;
         stall_q     <= stall_d;
         flush_q     <= flush_d;
         cmd_valid_q <= cmd_valid_d;
         rdv_q       <= rdv_d;
      end
   end

   assign commit_stall   = stall_q;
   assign flush          = flush_q;
   assign csr_cmd_valid  = cmd_valid_q;
   assign csr_cmd_kind   = kind_q;
   assign csr_cmd_cause  = cause_q;
   assign csr_cmd_epc    = epc_q;
   assign csr_cmd_tval   = tval_q;
   assign redirect_valid = rdv_q;
   assign redirect_pc    = rdpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        commit_valid, commit_ecall, commit_mret, commit_illegal;
   logic [63:0] commit_pc, commit_tval, mip, mie, mtvec, mepc;
   logic [1:0]  pmode;
   logic        mstatus_mie, pipe_empty, redirect_ready;
   logic        commit_stall, flush, csr_cmd_valid, csr_cmd_kind, redirect_valid;
   logic [63:0] csr_cmd_cause, csr_cmd_epc, csr_cmd_tval, redirect_pc;

   int checks   = 0;
   int failures = 0;

   trap_ctrl dut (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_ecall(commit_ecall), .commit_mret(commit_mret), .commit_illegal(commit_illegal),
      .commit_tval(commit_tval), .pmode(pmode), .mstatus_mie(mstatus_mie), .mip(mip), .mie(mie),
      .mtvec(mtvec), .mepc(mepc), .pipe_empty(pipe_empty), .redirect_ready(redirect_ready),
      .commit_stall(commit_stall), .flush(flush), .csr_cmd_valid(csr_cmd_valid),
      .csr_cmd_kind(csr_cmd_kind), .csr_cmd_cause(csr_cmd_cause), .csr_cmd_epc(csr_cmd_epc),
      .csr_cmd_tval(csr_cmd_tval), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      commit_valid = 1'b0; commit_ecall = 1'b0; commit_mret = 1'b0; commit_illegal = 1'b0;
      commit_pc = 64'd0; commit_tval = 64'd0; pmode = 2'd0; mstatus_mie = 1'b0;
      mip = 64'd0; mie = 64'd0; mtvec = 64'd0; mepc = 64'd0;
      pipe_empty = 1'b1; redirect_ready = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({commit_stall, flush, csr_cmd_valid, csr_cmd_kind, redirect_valid} !== 5'b0) begin failures++; $display("FAIL reset_ctrl: got %b expected 00000", {commit_stall, flush, csr_cmd_valid, csr_cmd_kind, redirect_valid}); end
      checks++; if ({csr_cmd_cause, csr_cmd_epc, csr_cmd_tval, redirect_pc} !== 256'd0) begin failures++; $display("FAIL reset_data: cause=%h epc=%h tval=%h pc=%h expected all 0", csr_cmd_cause, csr_cmd_epc, csr_cmd_tval, redirect_pc); end
      rst = 1'b0;
   endtask

   task automatic test_ecall_u();
      @(negedge clk);
      pmode = 2'd0; commit_valid = 1'b1; commit_ecall = 1'b1;
      commit_pc = 64'h8000_0010; mtvec = 64'h8000_1000; pipe_empty = 1'b1; redirect_ready = 1'b1;
      @(negedge clk);
      commit_valid = 1'b0; commit_ecall = 1'b0;
      checks++; if ({commit_stall, flush, csr_cmd_valid} !== 3'b110) begin failures++; $display("FAIL ecall_t1: got stall/flush/cmd=%b expected 110", {commit_stall, flush, csr_cmd_valid}); end
      @(negedge clk);
      checks++; if ({csr_cmd_valid, csr_cmd_kind, flush} !== 3'b100) begin failures++; $display("FAIL ecall_cmd: got valid/kind/flush=%b expected 100", {csr_cmd_valid, csr_cmd_kind, flush}); end
      checks++; if (csr_cmd_cause !== 64'd8) begin failures++; $display("FAIL ecall_cause: got %h expected 8", csr_cmd_cause); end
      checks++; if ({csr_cmd_epc, csr_cmd_tval} !== {64'h8000_0010, 64'd0}) begin failures++; $display("FAIL ecall_epc_tval: got %h %h expected 80000010 0", csr_cmd_epc, csr_cmd_tval); end
      @(negedge clk);
      checks++; if ({redirect_valid, csr_cmd_valid} !== 2'b10 || redirect_pc !== 64'h8000_1000) begin failures++; $display("FAIL ecall_redirect: got valid=%b cmd=%b pc=%h expected 1 0 80001000", redirect_valid, csr_cmd_valid, redirect_pc); end
      @(negedge clk);
      checks++; if ({redirect_valid, commit_stall} !== 2'b00) begin failures++; $display("FAIL ecall_idle: got rv/stall=%b expected 00", {redirect_valid, commit_stall}); end
   endtask

   task automatic test_vectored_irq();
      @(negedge clk);
      clear_inputs();
      mstatus_mie = 1'b1; mip = 64'h880; mie = 64'h880; mtvec = 64'h8000_1001;
      commit_valid = 1'b1; commit_ecall = 1'b1; pmode = 2'd3; commit_pc = 64'h8000_0200;
      @(negedge clk);
      commit_valid = 1'b0; commit_ecall = 1'b0; mip = 64'h8; mie = 64'h8;
      @(negedge clk);
      checks++; if (csr_cmd_valid !== 1'b1 || csr_cmd_cause !== 64'h8000_0000_0000_000B) begin failures++; $display("FAIL irq_cause: got valid=%b cause=%h expected 1 800000000000000b", csr_cmd_valid, csr_cmd_cause); end
      checks++; if ({csr_cmd_kind, csr_cmd_epc, csr_cmd_tval} !== {1'b0, 64'h8000_0200, 64'd0}) begin failures++; $display("FAIL irq_fields: got kind=%b epc=%h tval=%h expected 0 80000200 0", csr_cmd_kind, csr_cmd_epc, csr_cmd_tval); end
      @(negedge clk);
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_102C) begin failures++; $display("FAIL irq_vector_pc: got valid=%b pc=%h expected 1 8000102c", redirect_valid, redirect_pc); end
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      checks++; if ({commit_stall, csr_cmd_valid, redirect_valid} !== 3'b000) begin failures++; $display("FAIL irq_single_cmd: got %b expected 000", {commit_stall, csr_cmd_valid, redirect_valid}); end
   endtask

   task automatic test_illegal_mret();
      @(negedge clk);
      clear_inputs();
      commit_valid = 1'b1; commit_mret = 1'b1; pmode = 2'd0; commit_tval = 64'h3020_0073;
      commit_pc = 64'h8000_0300; mtvec = 64'h8000_1001;
      @(negedge clk);
      commit_valid = 1'b0; commit_mret = 1'b0;
      @(negedge clk);
      checks++; if ({csr_cmd_valid, csr_cmd_kind} !== 2'b10 || csr_cmd_cause !== 64'd2) begin failures++; $display("FAIL illmret_cause: got valid/kind=%b cause=%h expected 10 2", {csr_cmd_valid, csr_cmd_kind}, csr_cmd_cause); end
      checks++; if (csr_cmd_tval !== 64'h3020_0073 || csr_cmd_epc !== 64'h8000_0300) begin failures++; $display("FAIL illmret_tval: got tval=%h epc=%h expected 30200073 80000300", csr_cmd_tval, csr_cmd_epc); end
      @(negedge clk);
      checks++; if (redirect_pc !== 64'h8000_1000) begin failures++; $display("FAIL illmret_base_pc: got %h expected 80001000", redirect_pc); end
      @(negedge clk);
   endtask

   task automatic test_drain_backpressure();
      int flush_n = 0, cmd_n = 0, rv_n = 0, bad_pc = 0;
      @(negedge clk);
      clear_inputs();
      commit_valid = 1'b1; commit_mret = 1'b1; pmode = 2'd3; commit_pc = 64'h8000_0400;
      mepc = 64'h8000_4444; mtvec = 64'h8000_1000; pipe_empty = 1'b0; redirect_ready = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) begin commit_valid = 1'b0; commit_mret = 1'b0; end
         if (flush) flush_n++;
         if (csr_cmd_valid) begin
            cmd_n++;
            checks++; if (csr_cmd_kind !== 1'b1) begin failures++; $display("FAIL drain_kind: got %b expected 1", csr_cmd_kind); end
         end
         if (redirect_valid) begin
            rv_n++;
            if (redirect_pc !== 64'h8000_4444) bad_pc++;
         end
         pipe_empty = (k >= 5);
         redirect_ready = (k >= 9);
         if (k == 7) mepc = 64'hDEAD_BEEF_0000_0000;
      end
      checks++; if (flush_n !== 5) begin failures++; $display("FAIL drain_flush_cycles: got %0d expected 5", flush_n); end
      checks++; if (cmd_n !== 1) begin failures++; $display("FAIL drain_cmd_count: got %0d expected 1", cmd_n); end
      checks++; if (rv_n !== 3) begin failures++; $display("FAIL drain_redirect_cycles: got %0d expected 3", rv_n); end
      checks++; if (bad_pc !== 0) begin failures++; $display("FAIL drain_pc_hold: got %0d bad cycles expected 0", bad_pc); end
      checks++; if (commit_stall !== 1'b0) begin failures++; $display("FAIL drain_end_idle: got stall=%b expected 0", commit_stall); end
   endtask

   task automatic test_masked_irq();
      int busy = 0;
      @(negedge clk);
      clear_inputs();
      mstatus_mie = 1'b0; mip = 64'h80; mie = 64'h80; commit_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (commit_stall || flush) busy++;
      end
      checks++; if (busy !== 0) begin failures++; $display("FAIL masked_irq: got %0d busy cycles expected 0", busy); end
      busy = 0;
      mstatus_mie = 1'b1; mip = 64'h20; mie = 64'h20;
      repeat (3) begin
         @(negedge clk);
         if (commit_stall || flush) busy++;
      end
      checks++; if (busy !== 0) begin failures++; $display("FAIL ignored_irq_bit: got %0d busy cycles expected 0", busy); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_drain();
      int bad = 0;
      @(negedge clk);
      clear_inputs();
      commit_valid = 1'b1; commit_ecall = 1'b1; commit_pc = 64'h8000_0500; pipe_empty = 1'b0;
      @(negedge clk);
      commit_valid = 1'b0; commit_ecall = 1'b0;
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rstdrain_in_drain: got flush=%b expected 1", flush); end
      #1 rst = 1'b1;
      #1;
      checks++; if ({commit_stall, flush, csr_cmd_valid, csr_cmd_kind, redirect_valid} !== 5'b0 || {csr_cmd_cause, csr_cmd_epc, redirect_pc} !== 192'd0) begin failures++; $display("FAIL rstdrain_async: got ctrl=%b epc=%h expected all 0", {commit_stall, flush, csr_cmd_valid, csr_cmd_kind, redirect_valid}, csr_cmd_epc); end
      @(negedge clk);
      rst = 1'b0; pipe_empty = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (csr_cmd_valid || redirect_valid || commit_stall) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rstdrain_no_cmd: got %0d active cycles expected 0", bad); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      clear_inputs();
      commit_valid = 1'b1; commit_ecall = 1'b1; pmode = 2'd1; commit_pc = 64'h8000_0600; mtvec = 64'h8000_2000;
      @(negedge clk);
      commit_valid = 1'b0; commit_ecall = 1'b0;
      @(negedge clk);
      checks++; if (csr_cmd_valid !== 1'b1 || csr_cmd_cause !== 64'd9) begin failures++; $display("FAIL b2b_first_cause: got valid=%b cause=%h expected 1 9", csr_cmd_valid, csr_cmd_cause); end
      @(negedge clk);
      commit_valid = 1'b1; commit_illegal = 1'b1; commit_tval = 64'h0000_FFFF; commit_pc = 64'h8000_0700;
      @(negedge clk);
      checks++; if ({commit_stall, redirect_valid} !== 2'b00) begin failures++; $display("FAIL b2b_idle_gap: got stall/rv=%b expected 00", {commit_stall, redirect_valid}); end
      @(negedge clk);
      commit_valid = 1'b0; commit_illegal = 1'b0;
      checks++; if ({commit_stall, flush} !== 2'b11) begin failures++; $display("FAIL b2b_second_accept: got stall/flush=%b expected 11", {commit_stall, flush}); end
      @(negedge clk);
      checks++; if (csr_cmd_valid !== 1'b1 || csr_cmd_cause !== 64'd2 || csr_cmd_epc !== 64'h8000_0700) begin failures++; $display("FAIL b2b_second_cmd: got valid=%b cause=%h epc=%h expected 1 2 80000700", csr_cmd_valid, csr_cmd_cause, csr_cmd_epc); end
      @(negedge clk);
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_2000) begin failures++; $display("FAIL b2b_second_redirect: got valid=%b pc=%h expected 1 80002000", redirect_valid, redirect_pc); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_ecall_u();
      test_vectored_irq();
      test_illegal_mret();
      test_drain_backpressure();
      test_masked_irq();
      test_reset_mid_drain();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
